mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/mem_skid.sv | 34 +++
 rtl/mem_stage.sv | 152 +++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory stage: bus widths, field layout,
// opcode classes and the memory-stage FSM encoding.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int DST_W = 5;
  localparam int OP_W  = 4;

  // exbus: {valid, op, dst, res, stval}
  localparam int EX_W          = 1 + OP_W + DST_W + XLEN + XLEN;  // 74
  localparam int EX_VALID_BIT  = 73;
  localparam int EX_OP_HI      = 72;
  localparam int EX_OP_LO      = 69;
  localparam int EX_DST_HI     = 68;
  localparam int EX_DST_LO     = 64;
  localparam int EX_RES_HI     = 63;
  localparam int EX_RES_LO     = 32;
  localparam int EX_STVAL_HI   = 31;
  localparam int EX_STVAL_LO   = 0;

  // wbbus: {valid, dst, data}
  localparam int WB_W          = 1 + DST_W + XLEN;                // 38
  localparam int WB_VALID_BIT  = 37;
  localparam int WB_DST_HI     = 36;
  localparam int WB_DST_LO     = 32;
  localparam int WB_DATA_HI    = 31;
  localparam int WB_DATA_LO    = 0;

  // mem_bypass: {valid, data}
  localparam int BYP_W         = 1 + XLEN;                        // 33

  localparam logic [OP_W-1:0] OP_LOAD  = 4'b1000;
  localparam logic [OP_W-1:0] OP_STORE = 4'b1001;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // Field order matches the exbus bit layout above, so a plain cast works.
  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [DST_W-1:0] dst;
    logic [XLEN-1:0]  res;
    logic [XLEN-1:0]  stval;
  } ex_beat_t;

  // ALU ops and loads write a register; stores and NOPs do not.
  function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
    return (op[OP_W-1] == 1'b0) || (op == OP_LOAD);
  endfunction

  function automatic logic op_is_mem(input logic [OP_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_skid.sv
// One-entry skid buffer holding a single execute beat while the memory
// stage is busy. Push and pop are never requested in the same cycle.
module mem_skid
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [EX_W-1:0] din,
  output logic            valid,
  output logic [EX_W-1:0] dout
);

  logic            valid_q;
  logic [EX_W-1:0] data_q;

  // Capture on push, release on pop; data is kept as-is once released.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (push) begin
      valid_q <= 1'b1;
      data_q  <= din;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: ALU results pass straight to writeback, loads and stores
// hold a level request on the data-memory port until acknowledged.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no access in flight; issue from skid entry, else exbus
//   BUSY    | dmem_req held with latched addr/wdata/we until dmem_ack
module mem_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [EX_W-1:0]   exbus,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [WB_W-1:0]   wbbus,
  output logic [BYP_W-1:0]  mem_bypass,
  output logic [DST_W-1:0]  mem_dst,
  output logic              mem_stall,
  output logic              mem_ovf
);

  mem_state_e state, state_next;

  ex_beat_t ex_in;
  ex_beat_t skid_beat;
  ex_beat_t src;

  logic            skid_valid;
  logic [EX_W-1:0] skid_dout;
  logic            skid_push;
  logic            skid_pop;
  logic            ovf_set;
  logic            src_alu;
  logic            src_mem;
  logic            mem_done;

  logic [DST_W-1:0] lat_dst;
  logic [XLEN-1:0]  lat_addr;
  logic [XLEN-1:0]  lat_wdata;
  logic             lat_we;
  logic [WB_W-1:0]  wbbus_q;
  logic             ovf_q;

  assign ex_in     = ex_beat_t'(exbus);
  assign skid_beat = ex_beat_t'(skid_dout);

  mem_skid u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (exbus),
    .valid (skid_valid),
    .dout  (skid_dout)
  );

  // Source selection, skid control and overflow detection.
  always_comb begin
    src       = skid_valid ? skid_beat : ex_in;
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    ovf_set   = 1'b0;
    if (state == ST_IDLE) begin
      // Skid entry wins; a new beat alongside it has nowhere to go.
      skid_pop = skid_valid;
      ovf_set  = skid_valid && ex_in.valid;
    end else begin
      skid_push = ex_in.valid && !skid_valid;
      ovf_set   = ex_in.valid && skid_valid;
    end
    src_alu  = (state == ST_IDLE) && src.valid && !src.op[OP_W-1];
    src_mem  = (state == ST_IDLE) && src.valid && op_is_mem(src.op);
    mem_done = (state == ST_BUSY) && dmem_ack;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (src_mem)  state_next = ST_BUSY;
      ST_BUSY: if (dmem_ack) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Access latches, writeback register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_dst   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      wbbus_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (src_alu) begin
        wbbus_q <= {1'b1, src.dst, src.res};
      end else if (mem_done && !lat_we) begin
        wbbus_q <= {1'b1, lat_dst, dmem_rdata};
      end else begin
        wbbus_q <= '0;
      end
      // Latches only move when leaving IDLE, so dmem outputs hold in BUSY.
      if (src_mem) begin
        lat_dst   <= src.dst;
        lat_addr  <= src.res;
        lat_wdata <= src.stval;
        lat_we    <= (src.op == OP_STORE);
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Output decode from state, latches and skid occupancy.
  always_comb begin
    dmem_req   = (state == ST_BUSY);
    dmem_we    = (state == ST_BUSY) && lat_we;
    dmem_addr  = lat_addr;
    dmem_wdata = lat_wdata;
    mem_stall  = (state == ST_BUSY) || skid_valid;
    if ((state == ST_BUSY) && !lat_we) begin
      mem_dst = lat_dst;
    end else if (skid_valid && op_writes_reg(skid_beat.op)) begin
      mem_dst = skid_beat.dst;
    end else if (ex_in.valid && op_writes_reg(ex_in.op)) begin
      mem_dst = ex_in.dst;
    end else begin
      mem_dst = '0;
    end
  end

  assign wbbus      = wbbus_q;
  assign mem_bypass = {wbbus_q[WB_VALID_BIT], wbbus_q[WB_DATA_HI:WB_DATA_LO]};
  assign mem_ovf    = ovf_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import cpu_pkg::*;

  logic              clk;
  logic              reset;
  logic [EX_W-1:0]   exbus;
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;
  logic [WB_W-1:0]   wbbus;
  logic [BYP_W-1:0]  mem_bypass;
  logic [DST_W-1:0]  mem_dst;
  logic              mem_stall;
  logic              mem_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage dut (
    .clk        (clk),
    .reset      (reset),
    .exbus      (exbus),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wbbus      (wbbus),
    .mem_bypass (mem_bypass),
    .mem_dst    (mem_dst),
    .mem_stall  (mem_stall),
    .mem_ovf    (mem_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [EX_W-1:0] beat(input logic [3:0] op, input logic [4:0] dst,
                                           input logic [31:0] res, input logic [31:0] st);
    return {1'b1, op, dst, res, st};
  endfunction

  function automatic logic [WB_W-1:0] wb(input logic [4:0] dst, input logic [31:0] data);
    return {1'b1, dst, data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    exbus      = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    tick();
    tick();
    check("rst_wbbus",  64'(wbbus), 64'h0);
    check("rst_bypass", 64'(mem_bypass), 64'h0);
    check("rst_ovf",    64'(mem_ovf), 64'h0);
    check("rst_req",    64'(dmem_req), 64'h0);
    check("rst_stall",  64'(mem_stall), 64'h0);
    check("rst_dst",    64'(mem_dst), 64'h0);
    reset = 1'b0;
    tick();

    // ALU pass-through, latency 1
    exbus = beat(4'b0001, 5'd3, 32'h0000_0007, 32'h0);
    #1;
    check("alu_mem_dst", 64'(mem_dst), 64'd3);
    tick();
    exbus = '0;
    check("alu_wbbus",  64'(wbbus), 64'(wb(5'd3, 32'h7)));
    check("alu_bypass", 64'(mem_bypass), 64'(33'h1_0000_0007));
    check("alu_stall",  64'(mem_stall), 64'h0);

    // NOP: no mem_dst, no writeback
    exbus = beat(4'b1010, 5'd9, 32'h1234, 32'h0);
    #1;
    check("nop_mem_dst", 64'(mem_dst), 64'h0);
    tick();
    exbus = '0;
    check("nop_wbbus", 64'(wbbus), 64'h0);

    // LOAD with ack on the third BUSY cycle
    exbus = beat(OP_LOAD, 5'd5, 32'h100, 32'h0);
    #1;
    check("ld_dst_issue", 64'(mem_dst), 64'd5);
    tick();
    exbus = '0;
    check("ld_req_c1",   64'(dmem_req), 64'h1);
    check("ld_addr_c1",  64'(dmem_addr), 64'h100);
    check("ld_we_c1",    64'(dmem_we), 64'h0);
    check("ld_dst_c1",   64'(mem_dst), 64'd5);
    check("ld_stall_c1", 64'(mem_stall), 64'h1);
    check("ld_wb_c1",    64'(wbbus), 64'h0);
    tick();
    check("ld_req_c2",  64'(dmem_req), 64'h1);
    check("ld_addr_c2", 64'(dmem_addr), 64'h100);
    check("ld_dst_c2",  64'(mem_dst), 64'd5);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    check("ld_req_c3",  64'(dmem_req), 64'h1);
    check("ld_addr_c3", 64'(dmem_addr), 64'h100);
    check("ld_dst_c3",  64'(mem_dst), 64'd5);
    tick();
    dmem_ack = 1'b0;
    check("ld_wbbus",  64'(wbbus), 64'(wb(5'd5, 32'hDEAD_BEEF)));
    check("ld_req_end", 64'(dmem_req), 64'h0);
    check("ld_dst_end", 64'(mem_dst), 64'h0);

    // STORE acked on first BUSY cycle
    exbus = beat(OP_STORE, 5'd2, 32'h200, 32'h55);
    #1;
    check("st_dst_issue", 64'(mem_dst), 64'h0);
    tick();
    exbus    = '0;
    dmem_ack = 1'b1;
    check("st_req",   64'(dmem_req), 64'h1);
    check("st_we",    64'(dmem_we), 64'h1);
    check("st_addr",  64'(dmem_addr), 64'h200);
    check("st_wdata", 64'(dmem_wdata), 64'h55);
    check("st_dst",   64'(mem_dst), 64'h0);
    tick();
    dmem_ack = 1'b0;
    check("st_req_end", 64'(dmem_req), 64'h0);
    check("st_wbbus",   64'(wbbus), 64'h0);
    check("st_stall",   64'(mem_stall), 64'h0);

    // Stray ack in IDLE is ignored
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1234;
    tick();
    dmem_ack = 1'b0;
    check("idle_ack_wb",  64'(wbbus), 64'h0);
    check("idle_ack_req", 64'(dmem_req), 64'h0);

    // LOAD then in-flight ALU captured in skid
    exbus = beat(OP_LOAD, 5'd4, 32'h300, 32'h0);
    tick();
    exbus = beat(4'b0010, 5'd7, 32'd9, 32'h0);
    #1;
    check("skid_dst_busy", 64'(mem_dst), 64'd4);
    check("skid_stall0",   64'(mem_stall), 64'h1);
    tick();
    exbus = '0;
    check("skid_stall1", 64'(mem_stall), 64'h1);
    check("skid_dst1",   64'(mem_dst), 64'd4);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hABCD_0123;
    tick();
    dmem_ack = 1'b0;
    check("skid_ld_wb",  64'(wbbus), 64'(wb(5'd4, 32'hABCD_0123)));
    check("skid_stall2", 64'(mem_stall), 64'h1);
    check("skid_dst2",   64'(mem_dst), 64'd7);
    tick();
    check("skid_alu_wb", 64'(wbbus), 64'(wb(5'd7, 32'd9)));
    check("skid_stall3", 64'(mem_stall), 64'h0);
    check("skid_ovf",    64'(mem_ovf), 64'h0);

    // Third beat while skid full in BUSY: dropped, overflow sticky
    exbus = beat(OP_LOAD, 5'd6, 32'h400, 32'h0);
    tick();
    exbus = beat(4'b0011, 5'd8, 32'd1, 32'h0);
    tick();
    exbus = beat(4'b0100, 5'd10, 32'd2, 32'h0);
    tick();
    exbus = '0;
    check("ovf_set", 64'(mem_ovf), 64'h1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5;
    tick();
    dmem_ack = 1'b0;
    check("ovf_ld_wb", 64'(wbbus), 64'(wb(5'd6, 32'h5)));
    tick();
    check("ovf_skid_wb", 64'(wbbus), 64'(wb(5'd8, 32'd1)));
    tick();
    check("ovf_drop_wb", 64'(wbbus), 64'h0);
    check("ovf_sticky",  64'(mem_ovf), 64'h1);

    // Reset during BUSY abandons the access
    exbus = beat(OP_LOAD, 5'd12, 32'h500, 32'h0);
    tick();
    exbus = '0;
    check("rb_req", 64'(dmem_req), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rb_req_rst",   64'(dmem_req), 64'h0);
    check("rb_stall_rst", 64'(mem_stall), 64'h0);
    check("rb_ovf_rst",   64'(mem_ovf), 64'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF;
    tick();
    dmem_ack = 1'b0;
    check("rb_late_wb",  64'(wbbus), 64'h0);
    check("rb_late_req", 64'(dmem_req), 64'h0);
    exbus = beat(OP_LOAD, 5'd13, 32'h600, 32'h0);
    tick();
    exbus = '0;
    check("rb_ld_req",  64'(dmem_req), 64'h1);
    check("rb_ld_addr", 64'(dmem_addr), 64'h600);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h77;
    tick();
    dmem_ack = 1'b0;
    check("rb_ld_wb", 64'(wbbus), 64'(wb(5'd13, 32'h77)));

    // New beat in IDLE while skid still holds an entry: dropped
    exbus = beat(OP_LOAD, 5'd14, 32'h700, 32'h0);
    tick();
    exbus = beat(4'b0101, 5'd15, 32'h21, 32'h0);
    tick();
    exbus      = '0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h42;
    tick();
    dmem_ack = 1'b0;
    check("idrop_ld_wb", 64'(wbbus), 64'(wb(5'd14, 32'h42)));
    check("idrop_ovf0",  64'(mem_ovf), 64'h0);
    exbus = beat(4'b0110, 5'd16, 32'h99, 32'h0);
    #1;
    check("idrop_dst", 64'(mem_dst), 64'd15);
    tick();
    exbus = '0;
    check("idrop_wb",    64'(wbbus), 64'(wb(5'd15, 32'h21)));
    check("idrop_ovf",   64'(mem_ovf), 64'h1);
    check("idrop_stall", 64'(mem_stall), 64'h0);
    tick();
    check("idrop_none", 64'(wbbus), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
